// File: rtl/gc_stream_sink_pkg.sv
// Shared definitions for the stream sink: default sizes, stream tag encodings
// and the capture state machine encoding.
package gc_stream_sink_pkg;

    localparam int S = 5;
    localparam int K = 128;

    // tag[TAG_LABEL] set means a label packet; tag[1:0] then qualify the lanes
    localparam int         TAG_LABEL = 2;
    localparam logic [2:0] TAG_IDLE  = 3'b000;
    localparam logic [2:0] TAG_KEY   = 3'b001;
    localparam logic [2:0] TAG_TABLE = 3'b010;
    localparam logic [2:0] TAG_MASK  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/gc_dual_wr_ram.sv
// 2**S x K memory with two write ports (port 1 wins on equal address) and one
// registered read port that returns the pre-write contents on a collision.
module gc_dual_wr_ram #(
    parameter int S = 5,
    parameter int K = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we0,
    input  logic [S-1:0] addr0,
    input  logic [K-1:0] wdata0,
    input  logic         we1,
    input  logic [S-1:0] addr1,
    input  logic [K-1:0] wdata1,
    input  logic [S-1:0] rd_addr,
    output logic [K-1:0] rd_data
);

    logic [K-1:0] mem [2**S];

    // Port 1 is written last so it takes priority on an address match.
    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= wdata0;
        if (we1) mem[addr1] <= wdata1;
    end

    always_ff @(posedge clk) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/gc_stream_sink.sv
// Tagged dual-lane stream sink: captures labels and tables into memories,
// keys and an output mask into registers, and flags protocol errors.
module gc_stream_sink #(
    parameter int S = gc_stream_sink_pkg::S,
    parameter int K = gc_stream_sink_pkg::K
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   tag,
    input  logic [S-1:0] index0,
    input  logic [S-1:0] index1,
    input  logic [K-1:0] data0,
    input  logic [K-1:0] data1,
    input  logic         rd_sel,
    input  logic [S-1:0] rd_addr,
    output logic [K-1:0] rd_data,
    output logic [K-1:0] key0,
    output logic [K-1:0] key1,
    output logic [K-1:0] mask,
    output logic [S:0]   label_cnt,
    output logic [S:0]   table_cnt,
    output logic         key_valid,
    output logic         done,
    output logic         err
);

    import gc_stream_sink_pkg::*;

    localparam logic [S:0] CNT_MAX = {1'b1, {S{1'b0}}};

    state_t       state, state_nxt;
    logic         capture;
    logic         lbl_we0, lbl_we1, tbl_we;
    logic [1:0]   lbl_inc;
    logic         rd_sel_q;
    logic [K-1:0] lbl_rd, tbl_rd;

    function automatic logic [S:0] sat_add(input logic [S:0] c, input logic [1:0] inc);
        logic [S+1:0] sum;
        sum = {1'b0, c} + {{S{1'b0}}, inc};
        if (sum > {1'b0, CNT_MAX}) return CNT_MAX;
        return sum[S:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_CAPTURE;
            ST_CAPTURE:       if (!start && tag == TAG_MASK) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // A start pulse discards the word in its cycle; reset blocks memory writes.
    assign capture = rst && !start && (state == ST_CAPTURE);
    assign lbl_we0 = capture && tag[TAG_LABEL] && tag[0];
    assign lbl_we1 = capture && tag[TAG_LABEL] && tag[1];
    assign tbl_we  = capture && (tag == TAG_TABLE);
    assign lbl_inc = {1'b0, lbl_we0} + {1'b0, lbl_we1};

    always_ff @(posedge clk) begin
        if (!rst) begin
            key0      <= '0;
            key1      <= '0;
            mask      <= '0;
            label_cnt <= '0;
            table_cnt <= '0;
            key_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            rd_sel_q <= rd_sel;
            if (start) begin
                label_cnt <= '0;
                table_cnt <= '0;
                key_valid <= 1'b0;
                done      <= 1'b0;
                err       <= 1'b0;
            end else if (state == ST_CAPTURE) begin
                if (tag[TAG_LABEL]) begin
                    label_cnt <= sat_add(label_cnt, lbl_inc);
                end else begin
                    case (tag)
                        TAG_KEY: begin
                            key0      <= data0;
                            key1      <= data1;
                            key_valid <= 1'b1;
                            if (key_valid) err <= 1'b1;
                        end
                        TAG_TABLE: table_cnt <= sat_add(table_cnt, 2'd2);
                        TAG_MASK: begin
                            mask <= data0;
                            done <= 1'b1;
                            if (!key_valid) err <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    gc_dual_wr_ram #(.S(S), .K(K)) u_label_ram (
        .clk     (clk),
        .rst     (rst),
        .we0     (lbl_we0),
        .addr0   (index0),
        .wdata0  (data0),
        .we1     (lbl_we1),
        .addr1   (index1),
        .wdata1  (data1),
        .rd_addr (rd_addr),
        .rd_data (lbl_rd)
    );

    gc_dual_wr_ram #(.S(S), .K(K)) u_table_ram (
        .clk     (clk),
        .rst     (rst),
        .we0     (tbl_we),
        .addr0   (index0),
        .wdata0  (data0),
        .we1     (tbl_we),
        .addr1   (index1),
        .wdata1  (data1),
        .rd_addr (rd_addr),
        .rd_data (tbl_rd)
    );

    // Both read registers reset to zero, so the select mux keeps rd_data zero in reset.
    assign rd_data = rd_sel_q ? tbl_rd : lbl_rd;

endmodule

// File: tb/tb_gc_stream_sink.sv
// Directed bench for gc_stream_sink: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_gc_stream_sink;

    localparam int S = 5;
    localparam int K = 128;

    logic         clk = 1'b0;
    logic         rst, start, rd_sel;
    logic [2:0]   tag;
    logic [S-1:0] index0, index1, rd_addr;
    logic [K-1:0] data0, data1;
    logic [K-1:0] rd_data, key0, key1, mask;
    logic [S:0]   label_cnt, table_cnt;
    logic         key_valid, done, err;

    int checks   = 0;
    int failures = 0;

    localparam logic [K-1:0] VA  = {4{32'hA1A1_0003}};
    localparam logic [K-1:0] VB  = {4{32'hB2B2_0004}};
    localparam logic [K-1:0] VC  = {4{32'hC3C3_0033}};
    localparam logic [K-1:0] VK0 = {4{32'h4B30_4B30}};
    localparam logic [K-1:0] VK1 = {4{32'h4B31_4B31}};
    localparam logic [K-1:0] VT0 = {4{32'h7AB0_0000}};
    localparam logic [K-1:0] VT1 = {4{32'h7AB0_0001}};
    localparam logic [K-1:0] VT2 = {4{32'h7AB0_0002}};
    localparam logic [K-1:0] VT3 = {4{32'h7AB0_0003}};
    localparam logic [K-1:0] VM  = {4{32'h3A5C_0F0F}};
    localparam logic [K-1:0] VX  = {4{32'h5858_5858}};
    localparam logic [K-1:0] VY  = {4{32'h5959_5959}};

    gc_stream_sink #(.S(S), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tag       (tag),
        .index0    (index0),
        .index1    (index1),
        .data0     (data0),
        .data1     (data1),
        .rd_sel    (rd_sel),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .key0      (key0),
        .key1      (key1),
        .mask      (mask),
        .label_cnt (label_cnt),
        .table_cnt (table_cnt),
        .key_valid (key_valid),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stream input, then back to idle.
    task automatic step(input logic st, input logic [2:0] tg, input int i0, input int i1,
                        input logic [K-1:0] d0, input logic [K-1:0] d1);
        start  = st;
        tag    = tg;
        index0 = i0[S-1:0];
        index1 = i1[S-1:0];
        data0  = d0;
        data1  = d1;
        tick();
        start  = 1'b0;
        tag    = 3'b000;
    endtask

    task automatic rd(input logic sel, input int a, output logic [K-1:0] v);
        rd_sel  = sel;
        rd_addr = a[S-1:0];
        tick();
        v = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; tag = 3'b111; index0 = '0; index1 = '0;
        data0 = VX; data1 = VY; rd_sel = 1'b0; rd_addr = '0;
        tick(); tick();
        start = 1'b0; tag = 3'b000;
        checks++;
        if ({rd_data, key0, key1, mask} !== '0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rd_data, key0, key1, mask);
        end
        checks++;
        if ({label_cnt, table_cnt, key_valid, done, err} !== '0) begin
            failures++; $display("FAIL reset_ctl got=%0d/%0d/%b%b%b exp=0", label_cnt, table_cnt, key_valid, done, err);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_labels();
        logic [K-1:0] v;
        step(1, 3'b000, 0, 0, '0, '0);
        step(0, 3'b101, 3, 0, VA, '0);
        step(0, 3'b110, 0, 4, '0, VB);
        checks++;
        if (label_cnt !== 6'd2) begin
            failures++; $display("FAIL labels_cnt got=%0d exp=2", label_cnt);
        end
        rd(0, 3, v);
        checks++;
        if (v !== VA) begin failures++; $display("FAIL labels_rd3 got=%h exp=%h", v, VA); end
        rd(0, 4, v);
        checks++;
        if (v !== VB) begin failures++; $display("FAIL labels_rd4 got=%h exp=%h", v, VB); end
    endtask

    task automatic test_read_during_write();
        logic [K-1:0] v;
        rd_sel = 1'b0; rd_addr = 5'd3;
        step(0, 3'b101, 3, 0, VC, '0);
        checks++;
        if (rd_data !== VA) begin failures++; $display("FAIL rdw_old got=%h exp=%h", rd_data, VA); end
        rd(0, 3, v);
        checks++;
        if (v !== VC) begin failures++; $display("FAIL rdw_new got=%h exp=%h", v, VC); end
        checks++;
        if (label_cnt !== 6'd3) begin failures++; $display("FAIL rdw_cnt got=%0d exp=3", label_cnt); end
    endtask

    task automatic test_keys_tables();
        logic [K-1:0] v;
        step(1, 3'b000, 0, 0, '0, '0);
        step(0, 3'b001, 0, 0, VK0, VK1);
        checks++;
        if ({key_valid, err, done} !== 3'b100) begin
            failures++; $display("FAIL kt_keyflags got=%b exp=100", {key_valid, err, done});
        end
        step(0, 3'b010, 0, 1, VT0, VT1);
        step(0, 3'b010, 2, 3, VT2, VT3);
        step(0, 3'b011, 0, 0, VM, '0);
        checks++;
        if (key0 !== VK0 || key1 !== VK1) begin
            failures++; $display("FAIL kt_keys got=%h/%h exp=%h/%h", key0, key1, VK0, VK1);
        end
        checks++;
        if (table_cnt !== 6'd4 || mask !== VM) begin
            failures++; $display("FAIL kt_tbl_mask got=%0d/%h exp=4/%h", table_cnt, mask, VM);
        end
        checks++;
        if ({done, err, label_cnt} !== {1'b1, 1'b0, 6'd0}) begin
            failures++; $display("FAIL kt_done got=%b%b/%0d exp=10/0", done, err, label_cnt);
        end
        // DONE ignores stream words
        step(0, 3'b010, 5, 6, VX, VY);
        checks++;
        if (table_cnt !== 6'd4) begin failures++; $display("FAIL kt_done_ignore got=%0d exp=4", table_cnt); end
        rd(1, 1, v);
        checks++;
        if (v !== VT1) begin failures++; $display("FAIL kt_tbl1 got=%h exp=%h", v, VT1); end
        rd(1, 2, v);
        checks++;
        if (v !== VT2) begin failures++; $display("FAIL kt_tbl2 got=%h exp=%h", v, VT2); end
    endtask

    task automatic test_no_key();
        step(1, 3'b000, 0, 0, '0, '0);
        step(0, 3'b011, 0, 0, VM, '0);
        checks++;
        if ({done, err, key_valid} !== 3'b110) begin
            failures++; $display("FAIL nokey_flags got=%b exp=110", {done, err, key_valid});
        end
        step(0, 3'b101, 9, 0, VX, '0);
        checks++;
        if (label_cnt !== 6'd0) begin failures++; $display("FAIL nokey_ignore got=%0d exp=0", label_cnt); end
    endtask

    task automatic test_repeat_key();
        step(1, 3'b000, 0, 0, '0, '0);
        step(0, 3'b001, 0, 0, VK0, VK1);
        step(0, 3'b001, 0, 0, VX, VY);
        checks++;
        if ({err, key_valid} !== 2'b11 || key0 !== VX || key1 !== VY) begin
            failures++; $display("FAIL repkey got=%b%b/%h/%h exp=11/%h/%h", err, key_valid, key0, key1, VX, VY);
        end
        step(0, 3'b000, 0, 0, '0, '0);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL repkey_sticky got=%b exp=1", err); end
    endtask

    task automatic test_same_index();
        logic [K-1:0] v;
        step(1, 3'b000, 0, 0, '0, '0);
        step(0, 3'b111, 7, 7, VX, VY);
        checks++;
        if (label_cnt !== 6'd2) begin failures++; $display("FAIL same_cnt got=%0d exp=2", label_cnt); end
        rd(0, 7, v);
        checks++;
        if (v !== VY) begin failures++; $display("FAIL same_rd7 got=%h exp=%h", v, VY); end
    endtask

    task automatic test_saturation();
        step(1, 3'b000, 0, 0, '0, '0);
        for (int i = 0; i < 15; i++) step(0, 3'b111, 20, 21, VX, VY);
        checks++;
        if (label_cnt !== 6'd30) begin failures++; $display("FAIL sat_30 got=%0d exp=30", label_cnt); end
        step(0, 3'b111, 20, 21, VX, VY);
        checks++;
        if (label_cnt !== 6'd32) begin failures++; $display("FAIL sat_32 got=%0d exp=32", label_cnt); end
        step(0, 3'b111, 20, 21, VX, VY);
        step(0, 3'b101, 20, 21, VX, VY);
        checks++;
        if (label_cnt !== 6'd32) begin failures++; $display("FAIL sat_hold got=%0d exp=32", label_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [K-1:0] v;
        step(1, 3'b000, 0, 0, '0, '0);
        step(0, 3'b001, 0, 0, VK0, VK1);
        for (int i = 0; i < 5; i++) step(0, 3'b101, 8 + i, 0, VT0 + K'(i), '0);
        checks++;
        if (label_cnt !== 6'd5) begin failures++; $display("FAIL mid_cnt got=%0d exp=5", label_cnt); end
        // reset with start and a label write to index 8 in the same cycle
        rst = 1'b0; rd_sel = 1'b0; rd_addr = 5'd8;
        step(1, 3'b101, 8, 0, VX, '0);
        checks++;
        if ({rd_data, key0, key1, mask, label_cnt, table_cnt, key_valid, done, err} !== '0) begin
            failures++; $display("FAIL mid_reset_zero got=%h/%h/%0d/%b", rd_data, key0, label_cnt, key_valid);
        end
        rst = 1'b1;
        step(0, 3'b101, 9, 0, VX, '0);
        checks++;
        if (label_cnt !== 6'd0) begin failures++; $display("FAIL mid_idle_ignore got=%0d exp=0", label_cnt); end
        rd(0, 8, v);
        checks++;
        if (v !== VT0) begin failures++; $display("FAIL mid_rd8 got=%h exp=%h", v, VT0); end
        rd(0, 9, v);
        checks++;
        if (v !== VT0 + K'(1)) begin failures++; $display("FAIL mid_rd9 got=%h exp=%h", v, VT0 + K'(1)); end
    endtask

    task automatic test_rearm();
        logic [K-1:0] v;
        step(1, 3'b000, 0, 0, '0, '0);
        step(0, 3'b101, 10, 0, VB, '0);
        step(0, 3'b011, 0, 0, VM, '0);
        checks++;
        if ({done, err, label_cnt} !== {1'b1, 1'b1, 6'd1}) begin
            failures++; $display("FAIL rearm_pre got=%b%b/%0d exp=11/1", done, err, label_cnt);
        end
        step(1, 3'b000, 0, 0, '0, '0);
        checks++;
        if ({done, err, key_valid, label_cnt, table_cnt} !== '0) begin
            failures++; $display("FAIL rearm_clear got=%b%b%b/%0d/%0d exp=0", done, err, key_valid, label_cnt, table_cnt);
        end
        // restart in capture discards the word presented with start
        step(1, 3'b101, 3, 0, VX, '0);
        checks++;
        if (label_cnt !== 6'd0) begin failures++; $display("FAIL restart_cnt got=%0d exp=0", label_cnt); end
        rd(0, 3, v);
        checks++;
        if (v !== VC) begin failures++; $display("FAIL rearm_rd3 got=%h exp=%h", v, VC); end
        rd(0, 7, v);
        checks++;
        if (v !== VY) begin failures++; $display("FAIL rearm_rd7 got=%h exp=%h", v, VY); end
    endtask

    initial begin
        test_reset();
        test_labels();
        test_read_during_write();
        test_keys_tables();
        test_no_key();
        test_repeat_key();
        test_same_index();
        test_saturation();
        test_mid_reset();
        test_rearm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
